// File: rtl/merge_wr_ctrl.sv
// Six-lane merge write sequencer: flush, all-lanes join, burst framing with tlast, skew monitor.
// Optional MERGE_WR_CTRL_STATS_EN adds saturating beat/stall counters.
//
// state | meaning
// IDLE  | waiting for start, lanes not popped
// FLUSH | draining stale lane data for FLUSH_CYC cycles
// RUN   | joining all six lanes into 192-bit beats
// DRAIN | waiting for the output register to empty before done
module merge_wr_ctrl #(
  parameter int NUM_LANES = 6,
  parameter int LANE_W    = 32,
  parameter int FLUSH_CYC = 64,
  parameter int SKEW_MAX  = 16,
  parameter int CNT_W     = 16
) (
  input  logic                        axis_aclk,
  input  logic                        axis_rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [CNT_W-1:0]            burst_len,
  input  logic [CNT_W-1:0]            num_bursts,
  input  logic [NUM_LANES-1:0]        s_tvalid,
  input  logic [NUM_LANES*LANE_W-1:0] s_tdata,
  output logic [NUM_LANES-1:0]        s_tready,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [NUM_LANES*LANE_W-1:0] m_tdata,
  output logic                        m_tlast,
  output logic                        busy,
  output logic                        done,
`ifdef MERGE_WR_CTRL_STATS_EN
  output logic [31:0]                 stat_beats,
  output logic [31:0]                 stat_stalls,
`endif
  output logic                        skew_err
);

  localparam int DATA_W = NUM_LANES * LANE_W;
  localparam int FL_W   = $clog2(FLUSH_CYC + 1);
  localparam int SK_W   = $clog2(SKEW_MAX + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    burst_len_q, burst_len_d;
  logic [CNT_W-1:0]    num_bursts_q, num_bursts_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [SK_W-1:0]     skew_cnt_q, skew_cnt_d;
  logic                skew_err_q, skew_err_d;
  logic                stop_pend_q, stop_pend_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic                m_tlast_q, m_tlast_d;
  logic                done_q, done_d;
`ifdef MERGE_WR_CTRL_STATS_EN
  logic [31:0]         stat_beats_q, stat_beats_d;
  logic [31:0]         stat_stalls_q, stat_stalls_d;
`endif

  logic                all_valid, partial, join_ok, last_beat, stop_now;
  logic [CNT_W-1:0]    burst_nxt;

  always_comb begin
    state_d      = state_q;
    burst_len_d  = burst_len_q;
    num_bursts_d = num_bursts_q;
    beat_cnt_d   = beat_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    skew_cnt_d   = '0;
    skew_err_d   = skew_err_q;
    stop_pend_d  = stop_pend_q;
    m_tvalid_d   = m_tvalid_q && !m_tready;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    done_d       = 1'b0;
    s_tready     = '0;
    all_valid    = &s_tvalid;
    partial      = (|s_tvalid) && !all_valid;
    join_ok      = 1'b0;
    last_beat    = (beat_cnt_q == burst_len_q - 1'b1);
    burst_nxt    = burst_cnt_q + 1'b1;
    stop_now     = stop_pend_q || stop;
`ifdef MERGE_WR_CTRL_STATS_EN
    stat_beats_d  = stat_beats_q;
    stat_stalls_d = stat_stalls_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          burst_len_d  = (burst_len == '0) ? CNT_W'(1) : burst_len;
          num_bursts_d = num_bursts;
          beat_cnt_d   = '0;
          burst_cnt_d  = '0;
          skew_err_d   = 1'b0;
          stop_pend_d  = 1'b0;
          flush_cnt_d  = FL_W'(FLUSH_CYC - 1);
          state_d      = FLUSH;
`ifdef MERGE_WR_CTRL_STATS_EN
          stat_beats_d  = '0;
          stat_stalls_d = '0;
`endif
        end
      end
      FLUSH: begin
        s_tready = '1;
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (flush_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      RUN: begin
        join_ok  = all_valid && (!m_tvalid_q || m_tready);
        s_tready = {NUM_LANES{join_ok}};
        if (stop) stop_pend_d = 1'b1;
        if (partial) begin
          skew_cnt_d = (skew_cnt_q == SK_W'(SKEW_MAX)) ? skew_cnt_q : skew_cnt_q + 1'b1;
          if (skew_cnt_d == SK_W'(SKEW_MAX)) skew_err_d = 1'b1;
        end
        if (join_ok) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_tdata;
          m_tlast_d  = last_beat;
          if (last_beat) begin
            beat_cnt_d  = '0;
            burst_cnt_d = burst_nxt;
            if (stop_now || (num_bursts_q != '0 && burst_nxt == num_bursts_q))
              state_d = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (stop_now && beat_cnt_q == '0) begin
          state_d = DRAIN;
        end
`ifdef MERGE_WR_CTRL_STATS_EN
        if (join_ok && stat_beats_q != '1) stat_beats_d = stat_beats_q + 1'b1;
        if (all_valid && m_tvalid_q && !m_tready && stat_stalls_q != '1)
          stat_stalls_d = stat_stalls_q + 1'b1;
`endif
      end
      DRAIN: begin
        // leave as the last beat is accepted so done lands the cycle after
        if (!m_tvalid_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state_q      <= IDLE;
      burst_len_q  <= '0;
      num_bursts_q <= '0;
      beat_cnt_q   <= '0;
      burst_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      skew_cnt_q   <= '0;
      skew_err_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tlast_q    <= 1'b0;
      done_q       <= 1'b0;
`ifdef MERGE_WR_CTRL_STATS_EN
      stat_beats_q  <= '0;
      stat_stalls_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      num_bursts_q <= num_bursts_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      skew_cnt_q   <= skew_cnt_d;
      skew_err_q   <= skew_err_d;
      stop_pend_q  <= stop_pend_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tlast_q    <= m_tlast_d;
      done_q       <= done_d;
`ifdef MERGE_WR_CTRL_STATS_EN
      stat_beats_q  <= stat_beats_d;
      stat_stalls_q <= stat_stalls_d;
`endif
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign skew_err = skew_err_q;
`ifdef MERGE_WR_CTRL_STATS_EN
  assign stat_beats  = stat_beats_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_merge_wr_ctrl.sv
// Bench for merge_wr_ctrl: lane sources feed directed captures, a scoreboard checks every merged beat.
module tb_merge_wr_ctrl;
  localparam int FLUSH_CYC = 64;

  logic         axis_aclk = 1'b0;
  logic         axis_rst, start, stop, m_tready;
  logic [15:0]  burst_len, num_bursts;
  logic [5:0]   s_tvalid, s_tready;
  logic [191:0] s_tdata, m_tdata;
  logic         m_tvalid, m_tlast, busy, done, skew_err;
`ifdef MERGE_WR_CTRL_STATS_EN
  logic [31:0]  stat_beats, stat_stalls;
`endif

  merge_wr_ctrl dut (
    .axis_aclk(axis_aclk), .axis_rst(axis_rst), .start(start), .stop(stop),
    .burst_len(burst_len), .num_bursts(num_bursts),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .busy(busy), .done(done),
`ifdef MERGE_WR_CTRL_STATS_EN
    .stat_beats(stat_beats), .stat_stalls(stat_stalls),
`endif
    .skew_err(skew_err));

  always #5 axis_aclk = ~axis_aclk;

  int tests = 0, fails = 0;
  int acc = 0, stall_seen = 0;
  logic [192:0] sb[$];
  logic [191:0] src[$];
  int rd[6];
  logic [5:0] lane_en, hs;
  int tr_mode;

  function automatic void check(string nm, logic [192:0] act, logic [192:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void drive();
    logic [191:0] w;
    for (int i = 0; i < 6; i++) begin
      if (lane_en[i] && rd[i] < src.size()) begin
        w = src[rd[i]];
        s_tvalid[i] = 1'b1;
        s_tdata[i*32 +: 32] = w[i*32 +: 32];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*32 +: 32] = '0;
      end
    end
  endfunction

  // Lanes only advance on their own handshake, like the lane FIFOs would.
  task automatic tick();
    @(negedge axis_aclk);
    hs = s_tvalid & s_tready;
    @(posedge axis_aclk);
    #1;
    for (int i = 0; i < 6; i++) if (hs[i]) rd[i]++;
    if (tr_mode == 1) m_tready = ~m_tready;
    else if (tr_mode == 2) m_tready = 1'b0;
    else m_tready = 1'b1;
    drive();
    #1;
  endtask

  task automatic load(int tid, int n_load, int n_exp, int blen);
    logic [191:0] w;
    logic tl;
    src.delete();
    for (int i = 0; i < 6; i++) rd[i] = 0;
    for (int b = 0; b < n_load; b++) begin
      for (int i = 0; i < 6; i++) w[i*32 +: 32] = {8'(tid), 8'(b), 8'(i), 8'h5A};
      src.push_back(w);
      tl = ((b % blen) == blen - 1);
      if (b < n_exp) sb.push_back({tl, w});
    end
    drive();
    #1;
  endtask

  task automatic start_cap(string nm, int bl, int nb);
    src.delete();
    drive();
    burst_len = 16'(bl);
    num_bursts = 16'(nb);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_flush_first"}, 193'({busy, s_tready}), 193'({1'b1, 6'h3f}));
    repeat (FLUSH_CYC - 1) tick();
    check({nm, "_flush_last"}, 193'(s_tready), 193'(6'h3f));
    tick();
    check({nm, "_run_no_ready"}, 193'({busy, s_tready}), 193'({1'b1, 6'h00}));
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check({nm, "_done"}, 193'({done, busy}), 193'(2'b10));
    tick();
    check({nm, "_done_pulse"}, 193'(done), 193'(1'b0));
    check({nm, "_sb_empty"}, 193'(sb.size()), 193'(0));
  endtask

  logic         held;
  logic [192:0] held_v;
  always @(negedge axis_aclk) begin
    if (axis_rst) begin
      held = 1'b0;
    end else begin
      if (held && m_tvalid) check("hold_stable", {m_tlast, m_tdata}, held_v);
      if (&s_tvalid && m_tvalid && !m_tready) stall_seen++;
      if (m_tvalid && m_tready) begin
        acc++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected none", {m_tlast, m_tdata});
        end else begin
          check("beat", {m_tlast, m_tdata}, sb.pop_front());
        end
        held = 1'b0;
      end else if (m_tvalid) begin
        held = 1'b1;
        held_v = {m_tlast, m_tdata};
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, s0, n;
    axis_rst = 1'b1; start = 1'b0; stop = 1'b0; m_tready = 1'b1; tr_mode = 0;
    burst_len = '0; num_bursts = '0; lane_en = 6'h3f; s_tvalid = '0; s_tdata = '0;
    for (int i = 0; i < 6; i++) rd[i] = 0;
    repeat (3) tick();
    check("reset_flags", 193'({s_tready, m_tvalid, m_tlast, busy, done, skew_err}), 193'(0));
    check("reset_data", 193'(m_tdata), 193'(0));
    axis_rst = 1'b0;
    tick();

    // two bursts of four, everything flowing
    a0 = acc;
    start_cap("t1", 4, 2);
    load(1, 10, 8, 4);
    wait_done("t1");
    check("t1_beats", 193'(acc - a0), 193'(8));

    // lane 3 late: nothing may pop until it arrives
    start_cap("t2", 4, 1);
    lane_en = 6'b110111;
    load(2, 4, 4, 4);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_no_pop", 193'({s_tready, m_tvalid}), 193'(0));
    end
    lane_en = 6'h3f;
    wait_done("t2");
    check("t2_skew_clear", 193'(skew_err), 193'(0));

    // lane 5 missing for 16 RUN cycles
    start_cap("t3", 4, 1);
    lane_en = 6'b011111;
    load(3, 4, 4, 4);
    repeat (15) tick();
    lane_en = 6'h3f;
    tick();
    check("t3_skew_set", 193'(skew_err), 193'(1));
    wait_done("t3");
    check("t3_skew_held", 193'(skew_err), 193'(1));

    // unlimited bursts, stop mid-burst finishes the burst of eight
    a0 = acc;
    start_cap("t4", 8, 0);
    check("t4_skew_cleared", 193'(skew_err), 193'(0));
    load(4, 12, 8, 8);
    n = 0;
    while (acc < a0 + 3 && n < 100) begin
      tick();
      n++;
    end
    check("t4_reach_beat3", 193'(acc >= a0 + 3), 193'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t4");
    check("t4_beats", 193'(acc - a0), 193'(8));

    // back-pressure toggling, with an ignored start mid-capture
    a0 = acc;
    start_cap("t5", 4, 3);
    s0 = stall_seen;
    tr_mode = 1;
    load(5, 12, 12, 4);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5");
    tr_mode = 0;
    tick();
    check("t5_beats", 193'(acc - a0), 193'(12));
`ifdef MERGE_WR_CTRL_STATS_EN
    check("t5_stat_beats", 193'(stat_beats), 193'(12));
    check("t5_stat_stalls", 193'(stat_stalls), 193'(stall_seen - s0));
`endif

    // stop during flush returns straight to IDLE
    burst_len = 16'd4; num_bursts = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_flush_stop", 193'({busy, done}), 193'(2'b01));
    tick();
    check("t6_done_pulse", 193'({busy, done}), 193'(2'b00));

    // reset while a beat is held, then a fresh capture
    start_cap("t7", 4, 2);
    tr_mode = 2;
    m_tready = 1'b0;
    load(7, 8, 0, 4);
    repeat (3) tick();
    check("t7_held", 193'(m_tvalid), 193'(1));
    axis_rst = 1'b1;
    tick();
    check("t7_rst_flags", 193'({s_tready, m_tvalid, m_tlast, busy, done, skew_err}), 193'(0));
    check("t7_rst_data", 193'(m_tdata), 193'(0));
    axis_rst = 1'b0;
    tr_mode = 0;
    sb.delete();
    tick();
    a0 = acc;
    start_cap("t7b", 4, 1);
    load(8, 4, 4, 4);
    wait_done("t7b");
    check("t7b_beats", 193'(acc - a0), 193'(4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/merge_wr_ctrl.md
# merge_wr_ctrl

Capture sequencer for the six-lane merge write path. Takes the six 32-bit lane streams after their per-lane FIFOs and flushes stale lane data on start. It then joins lanes only when all six hold a word, and emits registered 192-bit beats framed into bursts with `tlast`. Lane skew is monitored and reported. It sits between the lane FIFOs and the merged-stream FIFO/DMA, replacing a free-running combiner with a start/stop-controlled one.

## Interface
- `NUM_LANES`, 6, number of input lanes (fixed 6 in this design; used for widths)
- `LANE_W`, 32, bits per lane
- `FLUSH_CYC`, 64, cycles of lane drain on start (≥ lane FIFO depth)
- `SKEW_MAX`, 16, max consecutive partial-valid cycles in RUN before error
- `CNT_W`, 16, width of burst length/count fields

- `axis_aclk` in 1 — sole clock
- `axis_rst` in 1 — synchronous, active-high reset
- `start` in 1 — pulse; accepted only in IDLE
- `stop` in 1 — pulse; graceful stop request
- `burst_len` in CNT_W — beats per burst, sampled at start; 0 treated as 1
- `num_bursts` in CNT_W — bursts per capture, sampled at start; 0 = unlimited until stop
- `s_tvalid` in 6 — lane valids, bit i = lane i
- `s_tdata` in 192 — lane i at [32i+31:32i]
- `s_tready` out 6 — lane readys
- `m_tvalid` out 1, `m_tready` in 1, `m_tdata` out 192, `m_tlast` out 1 — merged stream
- `busy` out 1 — state ≠ IDLE
- `done` out 1 — one-cycle pulse on return to IDLE
- `skew_err` out 1 — sticky, cleared by start or reset

## Operation
- States: IDLE, FLUSH, RUN, DRAIN.
- IDLE: `s_tready`=0. `start` latches `burst_len`/`num_bursts`, clears counters and `skew_err`, and moves to FLUSH.
- FLUSH: `s_tready`=all ones, data discarded, counter runs FLUSH_CYC cycles, then RUN. `stop` in FLUSH goes directly to IDLE (`done` pulses).
- RUN: join = all six `s_tvalid` high AND output register free (`!m_tvalid || m_tready`). On join, all six `s_tready` are high in the same cycle. The output register loads the concatenated data, and `m_tlast` is set if beat_cnt = burst_len−1. Otherwise `s_tready`=0; no lane is ever popped alone.
- Beat counter wraps to 0 after tlast beat; burst counter increments. Bursts reaching `num_bursts` (nonzero) → DRAIN.
- `stop` in RUN sets stop_pend. Capture continues to the end of the current burst (tlast beat joined), then DRAIN. If stop arrives while beat_cnt=0 and no beat pending, go to DRAIN immediately.
- DRAIN: `s_tready`=0; wait until output register empty (`!m_tvalid`), then IDLE with `done` pulse.
- Skew: in RUN, a cycle with 0 < popcount(`s_tvalid`) < 6 increments skew_cnt, otherwise skew_cnt clears. skew_cnt = SKEW_MAX sets `skew_err`; capture continues.
- `start` outside IDLE ignored; `stop` in IDLE/DRAIN ignored.

## Timing
- Reset: state IDLE, `s_tready`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `busy`=0, `done`=0, `skew_err`=0, all counters 0. Reset mid-capture drops any held beat.
- `start` at cycle 0 → `busy` at 1, `s_tready`=all ones cycles 1..FLUSH_CYC, RUN from FLUSH_CYC+1.
- Join-to-`m_tvalid` latency 1 cycle. Full throughput of 1 beat/cycle while `m_tready` held high.
- `m_tdata`/`m_tlast` stable while `m_tvalid && !m_tready`.
- `done` pulses in the cycle state returns to IDLE; `busy` falls same cycle.

## Configuration
- `MERGE_WR_CTRL_STATS_EN` defined: adds outputs `stat_beats` (32 bits, beats emitted this capture) and `stat_stalls` (32 bits, RUN cycles with all lanes valid but output register full). Both are cleared on start and saturating.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- burst_len=4, num_bursts=2, all lanes always valid, m_tready=1 → 8 beats, `m_tlast` on beats 4 and 8, `done` 1 cycle after last beat accepted.
- Lane 3 valid delayed 5 cycles vs others → no beat, all `s_tready`=0 until lane 3 valid; data of beat 0 = lane words in order; `skew_err` stays 0.
- Lane 5 held invalid 16 cycles in RUN, SKEW_MAX=16 → `skew_err`=1 and held until next start.
- num_bursts=0, burst_len=8, `stop` after beat 3 → beats 4..8 still emitted, tlast on 8, then `done`.
- m_tready toggling 1/0 → no beat lost or duplicated, `m_tdata` stable while stalled; with STATS_EN, stat_stalls equals count of blocked cycles.
- Reset asserted mid-burst with m_tvalid=1 → next cycle all outputs at reset values; new start yields a fresh burst beginning at beat 0.
